beta_decode: RTL

// - Beta decode stage: takes fetched 32-bit instruction words, emits the 6-bit ALU function code, register

---
 rtl/beta_decode_if.sv | 35 +++
 rtl/beta_decode.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/beta_decode_if.sv
// rtl/beta_decode_if.sv - fetch/decode/execute handshake bundle for beta_decode
interface beta_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_alufn;
    logic [4:0]  out_ra;
    logic [4:0]  out_rb;
    logic [4:0]  out_rc;
    logic        out_bsel;
    logic [31:0] out_lit;
    logic        out_wr;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic        out_branch;
    logic        out_illop;
    logic [31:0] out_pc;
    logic        br_resolve;
    logic        flush;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, br_resolve, flush,
        output in_ready, out_valid, out_alufn, out_ra, out_rb, out_rc, out_bsel,
               out_lit, out_wr, out_mem_rd, out_mem_wr, out_branch, out_illop, out_pc
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready, br_resolve, flush,
        input  in_ready, out_valid, out_alufn, out_ra, out_rb, out_rc, out_bsel,
               out_lit, out_wr, out_mem_rd, out_mem_wr, out_branch, out_illop, out_pc
    );
endinterface

// File: rtl/beta_decode.sv
// rtl/beta_decode.sv - Beta decode stage with registered output and branch/trap FSM
// Optional one-entry skid buffer (registered in_ready) enabled by BETA_DECODE_SKID_EN.
module beta_decode #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    beta_decode_if.slave bus
);
    typedef struct packed {
        logic [5:0]  alufn;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rc;
        logic        bsel;
        logic [31:0] lit;
        logic        wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        illop;
        logic [31:0] pc;
    } bundle_t;

    typedef enum logic [1:0] {ST_RUN, ST_WAIT_BR, ST_TRAP} state_e;

    localparam logic [5:0] FN_ADD = 6'b010000;
    localparam bundle_t RESET_BUNDLE = '{pc: RESET_PC, default: '0};

    function automatic bundle_t decode(input logic [31:0] instr, input logic [31:0] pc);
        bundle_t    b;
        logic [5:0] op;
        logic       ill;
        op      = instr[31:26];
        ill     = 1'b0;
        b       = '0;
        b.ra    = instr[20:16];
        b.rb    = instr[15:11];
        b.rc    = instr[25:21];
        b.lit   = {{16{instr[15]}}, instr[15:0]};
        b.pc    = pc;
        b.alufn = FN_ADD;
        if (op[5]) begin
            // OP and OPC share the function field; op[4] picks the literal operand
            b.wr   = 1'b1;
            b.bsel = op[4];
            case (op[3:0])
                4'h0:    b.alufn = 6'b010000;
                4'h1:    b.alufn = 6'b010001;
                4'h4:    b.alufn = 6'b000001;
                4'h5:    b.alufn = 6'b000010;
                4'h6:    b.alufn = 6'b000011;
                4'h8:    b.alufn = 6'b101000;
                4'h9:    b.alufn = 6'b101110;
                4'hA:    b.alufn = 6'b100110;
                4'hB:    b.alufn = 6'b101001;
                4'hC:    b.alufn = 6'b110000;
                4'hD:    b.alufn = 6'b110001;
                4'hE:    b.alufn = 6'b110011;
                default: ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h18, 6'h1F: begin b.mem_rd = 1'b1; b.wr = 1'b1; b.bsel = 1'b1; end
                6'h19:        begin b.mem_wr = 1'b1; b.bsel = 1'b1; b.rb = instr[25:21]; end
                6'h1B:        begin b.branch = 1'b1; b.wr = 1'b1; end
                6'h1C, 6'h1D: begin b.branch = 1'b1; b.wr = 1'b1; b.bsel = 1'b1; end
                default:      ill = 1'b1;
            endcase
        end
        if (ill) begin
            b.illop  = 1'b1;
            b.wr     = 1'b1;
            b.rc     = 5'd30;
            b.alufn  = FN_ADD;
            b.bsel   = 1'b0;
            b.mem_rd = 1'b0;
            b.mem_wr = 1'b0;
            b.branch = 1'b0;
        end
        return b;
    endfunction

    state_e  state_q, state_d;
    bundle_t out_q, out_d;
    logic    out_valid_q, out_valid_d;
    bundle_t dec;
    logic    in_ready;
    logic    accept;

    always_comb dec = decode(bus.in_instr, bus.in_pc);
    assign accept = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept && dec.illop)       state_d = ST_TRAP;
                    else if (accept && dec.branch) state_d = ST_WAIT_BR;
                end
                ST_WAIT_BR: if (bus.br_resolve) state_d = ST_RUN;
                ST_TRAP:    state_d = ST_TRAP;
                default:    state_d = ST_RUN;
            endcase
        end
    end

`ifdef BETA_DECODE_SKID_EN
    bundle_t skid_q, skid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    out_free;

    // in_ready depends only on flops (and the kill input), never on out_ready
    assign in_ready = (state_q == ST_RUN) && !skid_valid_q && !bus.flush;
    assign out_free = !out_valid_q || bus.out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= RESET_BUNDLE;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready) && !bus.flush;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_q       <= RESET_BUNDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_alufn  = out_q.alufn;
    assign bus.out_ra     = out_q.ra;
    assign bus.out_rb     = out_q.rb;
    assign bus.out_rc     = out_q.rc;
    assign bus.out_bsel   = out_q.bsel;
    assign bus.out_lit    = out_q.lit;
    assign bus.out_wr     = out_q.wr;
    assign bus.out_mem_rd = out_q.mem_rd;
    assign bus.out_mem_wr = out_q.mem_wr;
    assign bus.out_branch = out_q.branch;
    assign bus.out_illop  = out_q.illop;
    assign bus.out_pc     = out_q.pc;
endmodule
